// File: rtl/cheri_tsmap_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cheri_tsmap_arbiter_pkg
// Description : Shared types and helpers for the temporal-safety map path.
//               Holds the buffered bus request type, the all-bytes enable
//               constant and the byte-merge helper also used by the load path.
// Revision    : 1.0 - initial release
// ============================================================================
package cheri_tsmap_arbiter_pkg;

    // Full-word byte enable used for every read access.
    localparam logic [3:0] TSMAP_BE_ALL = 4'hF;

    // Stored bus addresses are widened to this width so one struct serves any
    // port address width up to 32 bits.
    localparam int unsigned TSMAP_ADDR_W = 32;

    // Width of the starvation counter; wide enough for the largest wait limit.
    localparam int unsigned TSMAP_WAIT_W = 8;

    // One secondary-port request as held in the pending buffer.
    typedef struct packed {
        logic                    we;
        logic [3:0]              be;
        logic [TSMAP_ADDR_W-1:0] addr;
        logic [31:0]             wdata;
    } tsmap_bus_req_t;

    // Overlay the enabled bytes of upd onto base.
    function automatic logic [31:0] tsmap_byte_merge(
        input logic [31:0] base,
        input logic [31:0] upd,
        input logic [3:0]  be
    );
        logic [31:0] res;
        res = base;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = upd[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cheri_tsmap_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cheri_tsmap_arbiter
// Description : Shares the single-port TS map SRAM between the core load
//               filter (absolute priority, never stalled) and a secondary bus
//               port that uses idle cycles. A one-entry pending buffer holds
//               the bus request; buffered writes are forwarded into core reads
//               of the same word so the core never sees stale revocation bits.
// Revision    : 1.0 - initial release
// ============================================================================
module cheri_tsmap_arbiter
    import cheri_tsmap_arbiter_pkg::*;
#(
    parameter int unsigned TSMapSize = 1024,
    parameter int unsigned AddrW     = 16,
    parameter int unsigned MaxWait   = 15
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             core_cs_i,
    input  logic [AddrW-1:0] core_addr_i,
    output logic [31:0]      core_rdata_o,

    input  logic             bus_req_i,
    input  logic             bus_we_i,
    input  logic [3:0]       bus_be_i,
    input  logic [AddrW-1:0] bus_addr_i,
    input  logic [31:0]      bus_wdata_i,
    output logic             bus_gnt_o,
    output logic             bus_rvalid_o,
    output logic [31:0]      bus_rdata_o,
    output logic             bus_err_o,

    output logic             mem_cs_o,
    output logic             mem_we_o,
    output logic [3:0]       mem_be_o,
    output logic [AddrW-1:0] mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    input  logic [31:0]      mem_rdata_i,

    output logic             starve_o
);

    localparam logic [TSMAP_WAIT_W-1:0] c_MAX_WAIT = TSMAP_WAIT_W'(MaxWait);
    localparam logic [TSMAP_ADDR_W-1:0] c_MAP_SIZE = TSMAP_ADDR_W'(TSMapSize);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                    r_out_en;     // low in reset and the cycle after
    logic                    r_buf_vld;
    tsmap_bus_req_t          r_buf;
    logic                    r_buf_err;
    logic [TSMAP_WAIT_W-1:0] r_wait_cnt;
    logic                    r_core_rd;    // core read issued last cycle
    logic [3:0]              r_fwd_be;
    logic [31:0]             r_fwd_wdata;
    logic                    r_rsp_vld;
    logic                    r_rsp_rd;     // response carries SRAM read data
    logic                    r_rsp_err;

    // ------------------------------------------------------------------
    // Per-cycle decisions
    // ------------------------------------------------------------------
    logic w_en;
    logic w_core_rd;
    logic w_issue;
    logic w_err_done;
    logic w_drain;
    logic w_accept;
    logic w_blocked;
    logic w_req_err;
    logic w_fwd_hit;

    // Every output is forced quiet while in reset and for one cycle after it.
    assign w_en       = rst_ni & r_out_en;
    assign w_core_rd  = w_en & core_cs_i;

    // A buffered SRAM request only goes out when the core leaves the port idle;
    // an out-of-range request retires on its own regardless of the core.
    assign w_issue    = w_en & r_buf_vld & ~r_buf_err & ~core_cs_i;
    assign w_err_done = w_en & r_buf_vld & r_buf_err;
    assign w_drain    = w_issue | w_err_done;
    assign w_blocked  = w_core_rd & r_buf_vld & ~r_buf_err;

    assign w_accept   = w_en & bus_req_i & (~r_buf_vld | w_drain);
    assign w_req_err  = TSMAP_ADDR_W'(bus_addr_i) >= c_MAP_SIZE;

    // The buffered write cannot reach the SRAM while the core reads, so the
    // pending bytes must be overlaid on the returned word.
    assign w_fwd_hit  = w_core_rd & r_buf_vld & r_buf.we & ~r_buf_err &
                        (TSMAP_ADDR_W'(core_addr_i) == r_buf.addr);

    // Pending buffer, starvation counter, forwarding and response tracking.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_out_en    <= 1'b0;
            r_buf_vld   <= 1'b0;
            r_buf       <= '0;
            r_buf_err   <= 1'b0;
            r_wait_cnt  <= '0;
            r_core_rd   <= 1'b0;
            r_fwd_be    <= '0;
            r_fwd_wdata <= '0;
            r_rsp_vld   <= 1'b0;
            r_rsp_rd    <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_out_en <= 1'b1;

            if (w_accept) begin
                r_buf_vld   <= 1'b1;
                r_buf.we    <= bus_we_i;
                r_buf.be    <= bus_be_i;
                r_buf.addr  <= TSMAP_ADDR_W'(bus_addr_i);
                r_buf.wdata <= bus_wdata_i;
                r_buf_err   <= w_req_err;
            end else if (w_drain) begin
                r_buf_vld   <= 1'b0;
            end

            if (w_issue) begin
                r_wait_cnt <= '0;
            end else if (w_blocked && (r_wait_cnt != c_MAX_WAIT)) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end

            r_core_rd   <= w_core_rd;
            r_fwd_be    <= w_fwd_hit ? r_buf.be    : 4'h0;
            r_fwd_wdata <= w_fwd_hit ? r_buf.wdata : 32'h0;

            r_rsp_vld   <= w_drain;
            r_rsp_rd    <= w_issue & ~r_buf.we;
            r_rsp_err   <= w_err_done;
        end
    end

    // SRAM port mux: core first, then the buffered bus request.
    always_comb begin
        mem_cs_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = '0;
        mem_wdata_o = 32'h0;
        if (w_core_rd) begin
            mem_cs_o   = 1'b1;
            mem_be_o   = TSMAP_BE_ALL;
            mem_addr_o = core_addr_i;
        end else if (w_issue) begin
            mem_cs_o    = 1'b1;
            mem_we_o    = r_buf.we;
            mem_be_o    = r_buf.we ? r_buf.be : TSMAP_BE_ALL;
            mem_addr_o  = r_buf.addr[AddrW-1:0];
            mem_wdata_o = r_buf.we ? r_buf.wdata : 32'h0;
        end
    end

    // Bus handshake and response; read data passes straight from the SRAM.
    always_comb begin
        bus_gnt_o    = w_accept;
        bus_rvalid_o = w_en & r_rsp_vld;
        bus_err_o    = w_en & r_rsp_vld & r_rsp_err;
        bus_rdata_o  = (w_en & r_rsp_vld & r_rsp_rd) ? mem_rdata_i : 32'h0;
    end

    // Core read data with buffered-write bytes overlaid; zero when no read.
    always_comb begin
        core_rdata_o = 32'h0;
        if (w_en && r_core_rd) begin
            core_rdata_o = tsmap_byte_merge(mem_rdata_i, r_fwd_wdata, r_fwd_be);
        end
    end

    // Alert once a buffered request has waited the full limit behind the core.
    always_comb begin
        starve_o = w_en & (r_wait_cnt == c_MAX_WAIT);
    end

endmodule
`default_nettype wire
